band_capture: RTL and testbench

- Writer-side counterpart to the band playback blocks: records a 16-bit signed band sample stream (44 kHz valid strobes in the 4.4 MHz domain) into a single-port band BRAM through its write port.
- Supports one-shot fill and continuous circular (loop) recording.
- Reports a completion pulse, the number of samples written, and a running peak magnitude for level metering.

---
 rtl/band_capture.sv | 135 +++++++++++++
 tb/tb_band_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/band_capture.sv
// band_capture: records a 16-bit signed band sample stream into the write port of a
// single-port band BRAM. It supports a one-shot fill of MEM_DEPTH words and continuous
// circular (loop) recording. It also reports completion, the sample count and a running
// peak magnitude for level metering.
//
// Ports:
//   clk        system clock (4.4 MHz)
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse, begins a capture at address 0
//   stop       one-cycle pulse, ends the capture early
//   loop_mode  1 = circular recording, 0 = one-shot (latched at start)
//   data_in    signed sample
//   valid_in   sample strobe
//   bram_we    BRAM write enable (wea)
//   bram_addr  BRAM address (addra)
//   bram_din   BRAM write data (dina)
//   busy       high while armed or capturing
//   done       one-cycle completion pulse
//   wrapped    one-cycle pulse when a loop capture writes the last address
//   wr_count   samples written in the current/most recent capture, saturating at MEM_DEPTH
//   peak_abs   maximum |sample| since start
module band_capture #(
    parameter int unsigned MEM_DEPTH  = 4036,
    parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_mode,
    input  logic signed [15:0]    data_in,
    input  logic                  valid_in,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [15:0]           bram_din,
    output logic                  busy,
    output logic                  done,
    output logic                  wrapped,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic [15:0]           peak_abs
);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

    localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FullCount = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    state_e                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  loop_q;
    logic [15:0]           sample_abs;
    logic                  last_write;

    // -32768 has no positive 16-bit counterpart, so it clamps to 32767.
    always_comb begin
        if (data_in == 16'sh8000) begin
            sample_abs = 16'h7fff;
        end else if (data_in[15]) begin
            sample_abs = ~data_in + 16'd1;
        end else begin
            sample_abs = data_in;
        end
    end

    // Accepted sample at the final address in one-shot mode finishes the capture.
    assign last_write = valid_in && (ptr == LastAddr) && !loop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            ptr       <= '0;
            loop_q    <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrapped   <= 1'b0;
            wr_count  <= '0;
            peak_abs  <= '0;
        end else begin
            bram_we <= 1'b0;
            done    <= 1'b0;
            wrapped <= 1'b0;
            case (state)
                StIdle: begin
                    // stop in the same cycle as start cancels it
                    if (start && !stop) begin
                        state    <= StArmed;
                        ptr      <= '0;
                        wr_count <= '0;
                        peak_abs <= '0;
                        loop_q   <= loop_mode;
                        busy     <= 1'b1;
                    end
                end
                StArmed: begin
                    // valid_in is deliberately dropped here
                    state <= StCapture;
                end
                StCapture: begin
                    if (valid_in) begin
                        bram_we   <= 1'b1;
                        bram_addr <= ptr;
                        bram_din  <= data_in;
                        if (wr_count != FullCount) begin
                            wr_count <= wr_count + 1'b1;
                        end
                        if (sample_abs > peak_abs) begin
                            peak_abs <= sample_abs;
                        end
                        if (ptr == LastAddr) begin
                            ptr     <= '0;
                            wrapped <= loop_q;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                    if (stop || last_write) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_band_capture.sv
module tb_band_capture;

    localparam int unsigned Depth = 8;
    localparam int unsigned AW    = 3;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic              loop_mode;
    logic signed [15:0] data_in;
    logic              valid_in;
    logic              bram_we;
    logic [AW-1:0]     bram_addr;
    logic [15:0]       bram_din;
    logic              busy;
    logic              done;
    logic              wrapped;
    logic [AW:0]       wr_count;
    logic [15:0]       peak_abs;

    int n_checks = 0;
    int n_pass   = 0;
    int we_cnt   = 0;
    int done_cnt = 0;
    int wrap_cnt = 0;
    int snap;

    band_capture #(
        .MEM_DEPTH (Depth),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .loop_mode(loop_mode),
        .data_in  (data_in),
        .valid_in (valid_in),
        .bram_we  (bram_we),
        .bram_addr(bram_addr),
        .bram_din (bram_din),
        .busy     (busy),
        .done     (done),
        .wrapped  (wrapped),
        .wr_count (wr_count),
        .peak_abs (peak_abs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (bram_we) we_cnt <= we_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (wrapped) wrap_cnt <= wrap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (got === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse; checks the ARMED cycle, then steps into CAPTURE.
    task automatic begin_capture(input logic lm);
        start     = 1'b1;
        loop_mode = lm;
        tick();
        start     = 1'b0;
        loop_mode = 1'b0;
        check("armed_busy", busy, 1);
        check("armed_wr_count", wr_count, 0);
        check("armed_peak", peak_abs, 0);
        tick();
    endtask

    // One sample strobe, optional coincident stop; checks the write cycle.
    task automatic send(input logic [15:0] d, input int exp_addr, input logic exp_done,
                        input logic exp_wrap, input logic with_stop, input int gap);
        data_in  = d;
        valid_in = 1'b1;
        stop     = with_stop;
        tick();
        valid_in = 1'b0;
        stop     = 1'b0;
        check("write_we", bram_we, 1);
        check("write_addr", bram_addr, exp_addr);
        check("write_din", bram_din, d);
        check("write_done", done, exp_done);
        check("write_wrapped", wrapped, exp_wrap);
        repeat (gap) tick();
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_done", done, 1);
        check("stop_busy", busy, 0);
        tick();
        check("after_done_clear", done, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        loop_mode = 1'b0;
        data_in   = '0;
        valid_in  = 1'b0;
        #1;
        check("rst_we", bram_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", wr_count, 0);
        check("rst_peak", peak_abs, 0);
        #11 rst_n = 1'b1;
        tick();

        // One-shot fill of all 8 words, 100 cycles apart.
        begin_capture(1'b0);
        for (int i = 0; i < 8; i++) begin
            send(16'(i + 1), i, (i == 7), 1'b0, 1'b0, 99);
        end
        check("oneshot_we_cnt", we_cnt, 8);
        check("oneshot_done_cnt", done_cnt, 1);
        check("oneshot_count", wr_count, 8);
        check("oneshot_busy", busy, 0);
        check("oneshot_peak", peak_abs, 8);

        // Loop mode, 10 samples: wraps once and the count saturates at 8.
        begin_capture(1'b1);
        for (int i = 0; i < 10; i++) begin
            send(16'(i + 16), i % 8, 1'b0, (i == 7), 1'b0, 3);
        end
        check("loop_busy", busy, 1);
        check("loop_count", wr_count, 8);
        check("loop_wrap_cnt", wrap_cnt, 1);
        check("loop_we_cnt", we_cnt, 18);
        pulse_stop();
        check("loop_done_cnt", done_cnt, 2);

        // Early stop coincident with the third sample.
        begin_capture(1'b0);
        send(16'd1, 0, 1'b0, 1'b0, 1'b0, 2);
        send(16'd2, 1, 1'b0, 1'b0, 1'b0, 2);
        send(16'd3, 2, 1'b1, 1'b0, 1'b1, 2);
        check("early_count", wr_count, 3);
        check("early_busy", busy, 0);
        check("early_done_cnt", done_cnt, 3);

        // Peak tracking including the -32768 clamp.
        begin_capture(1'b0);
        send(16'd100, 0, 1'b0, 1'b0, 1'b0, 1);
        check("peak_100", peak_abs, 100);
        send(16'h8000, 1, 1'b0, 1'b0, 1'b0, 1);
        check("peak_min_clamp", peak_abs, 16'h7fff);
        send(16'd5, 2, 1'b0, 1'b0, 1'b0, 1);
        check("peak_hold", peak_abs, 16'h7fff);
        pulse_stop();
        check("peak_after_done", peak_abs, 16'h7fff);
        begin_capture(1'b0);
        pulse_stop();

        // start with stop in IDLE is cancelled.
        snap  = we_cnt;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("cancel_busy", busy, 0);
        tick();
        check("cancel_busy2", busy, 0);
        check("cancel_no_write", we_cnt, snap);

        // start during CAPTURE is ignored.
        begin_capture(1'b0);
        send(16'd7, 0, 1'b0, 1'b0, 1'b0, 2);
        send(16'd8, 1, 1'b0, 1'b0, 1'b0, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_count", wr_count, 2);
        tick();
        send(16'd9, 2, 1'b0, 1'b0, 1'b0, 1);
        check("restart_count2", wr_count, 3);
        pulse_stop();

        // Asynchronous reset mid-capture after 4 writes.
        begin_capture(1'b0);
        for (int i = 0; i < 4; i++) begin
            send(16'(i + 40), i, 1'b0, 1'b0, 1'b0, 2);
        end
        snap = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_count", wr_count, 0);
        check("arst_peak", peak_abs, 0);
        check("arst_addr", bram_addr, 0);
        check("arst_din", bram_din, 0);
        check("arst_we", bram_we, 0);
        #3 rst_n = 1'b1;
        tick();
        tick();
        check("arst_no_done", done_cnt, snap);
        begin_capture(1'b0);
        send(16'd77, 0, 1'b0, 1'b0, 1'b0, 1);
        check("arst_restart_count", wr_count, 1);
        pulse_stop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
